// File: rtl/cadence_gen.sv
// cadence_gen
// -----------------------------------------------------------------------------
// Cadence sensor emulator. Produces a square wave with programmable clean
// high/low phase lengths. Each clean edge can optionally be preceded by a
// contact-bounce burst of glitch pairs. Clean edges are flagged with one-cycle
// pulses, and clean rising edges are counted so that checkers can correlate
// them with a downstream cadence filter.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   en           in   run enable (level). Sampled on IDLE exit and at the end
//                     of each LOW phase only.
//   half_period  in   clean phase length in cycles (0 behaves as 1)
//   bounce_cnt   in   glitch pairs before each clean edge (0 = none)
//   bounce_gap   in   each glitch segment lasts bounce_gap+1 cycles
//   cadence      out  emulated sensor output (registered)
//   edge_rise    out  pulse on the first cycle of each clean HIGH phase
//   edge_fall    out  pulse on the first cycle of each LOW phase that follows
//                     HIGH or BNC_F
//   rev_cnt      out  clean rising edges since reset, wrapping
//   busy         out  high in every state except IDLE
//   dbg_state    out  current FSM state encoding, for checkers
//
// Handshake: there is no valid/ready pair. en is a plain level request, and
// every output is a registered per-cycle value that is valid on every cycle.
// -----------------------------------------------------------------------------
module cadence_gen #(
  parameter int PER_W = 24,
  parameter int BNC_W = 8,
  parameter int REV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PER_W-1:0] half_period,
  input  logic [BNC_W-1:0] bounce_cnt,
  input  logic [BNC_W-1:0] bounce_gap,
  output logic             cadence,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic [REV_W-1:0] rev_cnt,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // The toggle counter is one bit wider than the bounce operand so that
  // 2*bounce_cnt segments fit (for example, 255 pairs gives 510 segments).
  localparam int TOG_W = BNC_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOW   = 3'd1,
    S_BNC_R = 3'd2,
    S_HIGH  = 3'd3,
    S_BNC_F = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PER_W-1:0]   phase_q, phase_d;   // cycles left in a clean phase, minus 1
  logic [BNC_W-1:0]   seg_q, seg_d;       // cycles left in a glitch segment, minus 1
  logic [TOG_W-1:0]   tog_q, tog_d;       // segments left in the burst, minus 1
  logic [BNC_W-1:0]   gap_q, gap_d;       // bounce_gap captured at burst entry
  logic               cadence_q, cadence_d;
  logic               edge_rise_q, edge_rise_d;
  logic               edge_fall_q, edge_fall_d;
  logic [REV_W-1:0]   rev_q, rev_d;
  logic               busy_q, busy_d;

  // Load values are derived from the live operands. Sampling them only on a
  // state entry is what makes a mid-state change take effect at the next entry.
  logic [PER_W-1:0]   phase_load;
  logic [TOG_W-1:0]   tog_load;
  logic               bounce_on;

  // A state change is requested as (enter, tgt). The entry actions, which are
  // counter loads and output values, are applied in a single place below.
  logic               enter;
  state_t             tgt;

  always_comb begin
    phase_load = (half_period == '0) ? '0 : (half_period - PER_W'(1));
    tog_load   = {bounce_cnt, 1'b0} - TOG_W'(1);
    bounce_on  = (bounce_cnt != '0);
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    seg_d       = seg_q;
    tog_d       = tog_q;
    gap_d       = gap_q;
    cadence_d   = cadence_q;
    edge_rise_d = 1'b0;
    edge_fall_d = 1'b0;
    rev_d       = rev_q;
    busy_d      = busy_q;
    enter       = 1'b0;
    tgt         = S_IDLE;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          enter = 1'b1;
          tgt   = S_LOW;
        end
      end

      S_LOW: begin
        if (phase_q == '0) begin
          enter = 1'b1;
          if (!en)            tgt = S_IDLE;
          else if (bounce_on) tgt = S_BNC_R;
          else                tgt = S_HIGH;
        end else begin
          phase_d = phase_q - PER_W'(1);
        end
      end

      // en is deliberately ignored from here until the end of the next LOW
      // phase, so a started revolution always completes.
      S_HIGH: begin
        if (phase_q == '0) begin
          enter = 1'b1;
          tgt   = bounce_on ? S_BNC_F : S_LOW;
        end else begin
          phase_d = phase_q - PER_W'(1);
        end
      end

      S_BNC_R, S_BNC_F: begin
        if (seg_q == '0) begin
          if (tog_q == '0) begin
            enter = 1'b1;
            tgt   = (state_q == S_BNC_R) ? S_HIGH : S_LOW;
          end else begin
            // The next glitch segment starts with the opposite level.
            tog_d     = tog_q - TOG_W'(1);
            seg_d     = gap_q;
            cadence_d = ~cadence_q;
          end
        end else begin
          seg_d = seg_q - BNC_W'(1);
        end
      end

      default: begin
        enter = 1'b1;
        tgt   = S_IDLE;
      end
    endcase

    if (enter) begin
      state_d = tgt;
      case (tgt)
        S_IDLE: begin
          cadence_d = 1'b0;
          busy_d    = 1'b0;
        end
        S_LOW: begin
          cadence_d   = 1'b0;
          busy_d      = 1'b1;
          phase_d     = phase_load;
          // A LOW phase entered from IDLE is not a clean falling edge.
          edge_fall_d = (state_q == S_HIGH) || (state_q == S_BNC_F);
        end
        S_HIGH: begin
          cadence_d   = 1'b1;
          busy_d      = 1'b1;
          phase_d     = phase_load;
          edge_rise_d = 1'b1;
          rev_d       = rev_q + REV_W'(1);
        end
        S_BNC_R, S_BNC_F: begin
          // A rising burst starts high (1,0,...,0). A falling burst starts
          // low (0,1,...,1).
          cadence_d = (tgt == S_BNC_R);
          busy_d    = 1'b1;
          seg_d     = bounce_gap;
          gap_d     = bounce_gap;
          tog_d     = tog_load;
        end
        default: begin
          cadence_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  // Reset overrides en and aborts any burst with cadence forced low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      seg_q       <= '0;
      tog_q       <= '0;
      gap_q       <= '0;
      cadence_q   <= 1'b0;
      edge_rise_q <= 1'b0;
      edge_fall_q <= 1'b0;
      rev_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      tog_q       <= tog_d;
      gap_q       <= gap_d;
      cadence_q   <= cadence_d;
      edge_rise_q <= edge_rise_d;
      edge_fall_q <= edge_fall_d;
      rev_q       <= rev_d;
      busy_q      <= busy_d;
    end
  end

  assign cadence   = cadence_q;
  assign edge_rise = edge_rise_q;
  assign edge_fall = edge_fall_q;
  assign rev_cnt   = rev_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cadence_gen.sv
module tb_cadence_gen;

  localparam int W = 20;  // {busy, cadence, edge_rise, edge_fall, rev_cnt[15:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [23:0] half_period = 24'd0;
  logic [7:0]  bounce_cnt  = 8'd0;
  logic [7:0]  bounce_gap  = 8'd0;
  logic        cadence, edge_rise, edge_fall, busy;
  logic [15:0] rev_cnt;
  logic [2:0]  dbg_state;

  // Small-counter instance for the wrap check.
  logic        en4 = 1'b0;
  logic [23:0] half_period4 = 24'd1;
  logic [7:0]  bounce_cnt4  = 8'd0;
  logic [7:0]  bounce_gap4  = 8'd0;
  logic        cadence4, edge_rise4, edge_fall4, busy4;
  logic [3:0]  rev_cnt4;
  logic [2:0]  dbg_state4;

  cadence_gen dut (
    .clk(clk), .rst(rst), .en(en), .half_period(half_period),
    .bounce_cnt(bounce_cnt), .bounce_gap(bounce_gap), .cadence(cadence),
    .edge_rise(edge_rise), .edge_fall(edge_fall), .rev_cnt(rev_cnt),
    .busy(busy), .dbg_state(dbg_state)
  );

  cadence_gen #(.REV_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .half_period(half_period4),
    .bounce_cnt(bounce_cnt4), .bounce_gap(bounce_gap4), .cadence(cadence4),
    .edge_rise(edge_rise4), .edge_fall(edge_fall4), .rev_cnt(rev_cnt4),
    .busy(busy4), .dbg_state(dbg_state4)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  sample_idx = 0;
  int  model_rev  = 0;
  bit  mon_on = 1'b0;

  function automatic void push(input bit b, input bit c, input bit er, input bit ef);
    exp_q.push_back({b, c, er, ef, 16'(model_rev)});
  endfunction

  // Monitor: one expected word per cycle, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      logic [W-1:0] act, exp_w;
      act = {busy, cadence, edge_rise, edge_fall, rev_cnt};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL underflow sample %0d: got %h, no expected value queued", sample_idx, act);
      end else begin
        exp_w = exp_q.pop_front();
        if (act !== exp_w) begin
          n_fail++;
          $display("FAIL sample %0d {busy,cad,rise,fall,rev}: got %b%b%b%b/%0d required %b%b%b%b/%0d",
                   sample_idx, act[19], act[18], act[17], act[16], act[15:0],
                   exp_w[19], exp_w[18], exp_w[17], exp_w[16], exp_w[15:0]);
        end
      end
      sample_idx++;
    end
  end

  // ---------------- driver tasks ----------------
  // Every task starts and ends on a negedge. The expectation for the next
  // sample has not been queued yet at that point.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      push(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
  endtask

  // Reference waveform for one enable burst. The first LOW phase uses hp0 and
  // every later phase uses hp1, because hp1 is applied one cycle after start.
  // en is dropped right after the last clean rise, so the run ends with a
  // full LOW phase followed by IDLE.
  task automatic run(input int hp0, input int hp1, input int bc, input int bg, input int revs);
    int n0, n1, sl, len, rise_at;
    n0 = (hp0 == 0) ? 1 : hp0;
    n1 = (hp1 == 0) ? 1 : hp1;
    sl = bg + 1;
    half_period = 24'(hp0);
    bounce_cnt  = 8'(bc);
    bounce_gap  = 8'(bg);
    en = 1'b1;
    len = 0;
    rise_at = 0;
    for (int r = 0; r < revs; r++) begin
      for (int i = 0; i < ((r == 0) ? n0 : n1); i++) begin
        push(1'b1, 1'b0, 1'b0, (r > 0) && (i == 0)); len++;
      end
      for (int s = 0; s < 2 * bc; s++)
        for (int j = 0; j < sl; j++) begin
          push(1'b1, (s % 2) == 0, 1'b0, 1'b0); len++;
        end
      model_rev = (model_rev + 1) % 65536;
      rise_at = len;
      for (int i = 0; i < n1; i++) begin
        push(1'b1, 1'b1, i == 0, 1'b0); len++;
      end
      for (int s = 0; s < 2 * bc; s++)
        for (int j = 0; j < sl; j++) begin
          push(1'b1, (s % 2) == 1, 1'b0, 1'b0); len++;
        end
    end
    for (int i = 0; i < n1; i++) begin
      push(1'b1, 1'b0, 1'b0, i == 0); len++;
    end
    @(negedge clk);
    half_period = 24'(hp1);
    repeat (rise_at) @(negedge clk);
    en = 1'b0;
    repeat (len - rise_at - 1) @(negedge clk);
  endtask

  // Start a bouncing run, assert reset in the third segment of the first
  // rising burst, then restart directly with en still high.
  task automatic reset_in_bounce(input int hp, input int bc, input int bg);
    int n, sl, s;
    n  = (hp == 0) ? 1 : hp;
    sl = bg + 1;
    half_period = 24'(hp);
    bounce_cnt  = 8'(bc);
    bounce_gap  = 8'(bg);
    en = 1'b1;
    s = 0;
    for (int i = 0; i < n; i++) begin push(1'b1, 1'b0, 1'b0, 1'b0); s++; end
    for (int i = 0; i < sl; i++) begin push(1'b1, 1'b1, 1'b0, 1'b0); s++; end
    for (int i = 0; i < sl; i++) begin push(1'b1, 1'b0, 1'b0, 1'b0); s++; end
    push(1'b1, 1'b1, 1'b0, 1'b0); s++;
    repeat (s) @(negedge clk);
    rst = 1'b1;
    model_rev = 0;
    push(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run(hp, hp, bc, bg, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt4;
    @(negedge clk);
    push(1'b0, 1'b0, 1'b0, 1'b0);
    mon_on = 1'b1;
    @(negedge clk);
    push(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3);

    run(10, 10, 0, 0, 3);        // plain square wave, rev_cnt reaches 3
    idle_cycles(2);
    run(0, 0, 0, 0, 4);          // half_period 0 behaves as 1
    idle_cycles(2);
    run(100, 100, 3, 4, 2);      // bounce bursts, 260-cycle period
    idle_cycles(2);
    run(6, 3, 1, 0, 2);          // half_period changed mid-LOW
    idle_cycles(2);
    reset_in_bounce(5, 3, 2);
    idle_cycles(2);

    for (int k = 0; k < 8; k++) begin
      run($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(1, 3));
      idle_cycles($urandom_range(1, 3));
    end

    mon_on = 1'b0;
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover expectations: got %0d queued, required 0", exp_q.size());
    end

    // Wrap check on the 4-bit instance: 17 clean rises must read back as 1.
    cnt4 = 0;
    en4 = 1'b1;
    for (int c = 0; c < 400 && cnt4 < 17; c++) begin
      @(negedge clk);
      if (edge_rise4) cnt4++;
    end
    en4 = 1'b0;
    n_tests++;
    if (cnt4 != 17) begin
      n_fail++;
      $display("FAIL wrap rise count: got %0d required 17 within 400 cycles", cnt4);
    end
    n_tests++;
    if (rev_cnt4 !== 4'(17 % 16)) begin
      n_fail++;
      $display("FAIL wrap rev_cnt: got %0d required %0d", rev_cnt4, 17 % 16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
